// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings, FSM state, pending-update entry and saturating-counter helper
package bp_pkg;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    localparam int BP_IDX_W = 16;
    typedef enum logic {BP_INIT, BP_RUN} bp_state_e;
    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
        logic                pred;
    } bp_entry_t;
    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: pending branch-update FIFO; ports: clk, reset, push/push_data, pop, head, count, full, empty
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  bp_entry_t        push_data,
    input  logic             pop,
    output bp_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    bp_entry_t mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full    = cnt_q == CNT_W'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_comb begin
        wr_d  = do_push ? (wr_q == PTR_W'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = do_pop ? (rd_q == PTR_W'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit counter branch history table with init sweep, predict port and queued resolve updates
// ports: clk, reset (sync, active-high); pred_valid/pred_pc/pred_ready -> pred_out_valid/pred_taken;
// res_valid/res_pc/res_taken/res_pred/res_ready; init_done; BP_PERF_CNT_EN adds perf_pred_cnt/perf_mispred_cnt
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int         BHT_DEPTH  = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_STATE = WNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    output logic        pred_out_valid,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic        res_pred,
    output logic        res_ready,
    output logic        init_done
`ifdef BP_PERF_CNT_EN
    ,
    output logic [15:0] perf_pred_cnt,
    output logic [15:0] perf_mispred_cnt
`endif
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    logic [1:0] bht_q [BHT_DEPTH];
    logic [1:0] bht_d [BHT_DEPTH];
    bp_state_e state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d, pidx, uidx;
    logic init_done_q, init_done_d, pred_out_valid_q, pred_out_valid_d, pred_taken_q, pred_taken_d;
    logic run, full, empty, do_pred, do_upd, push;
    logic [CNT_W-1:0] fifo_count;
    bp_entry_t head, push_entry;
    logic unused_bits;
    assign run        = state_q == BP_RUN;
    assign pred_ready = run & ~full;
    assign res_ready  = run & ~full;
    assign push       = res_valid & res_ready;
    assign do_pred    = pred_valid & pred_ready;
    // a full queue starves prediction; otherwise updates only use idle slots
    assign do_upd     = run & ~empty & (full | ~pred_valid);
    assign pidx       = pred_pc[IDX_W-1:0];
    assign uidx       = head.idx[IDX_W-1:0];
    assign push_entry = '{idx: BP_IDX_W'(res_pc[IDX_W-1:0]), taken: res_taken, pred: res_pred};
    assign unused_bits = ^{pred_pc, res_pc, head, fifo_count};
    assign pred_out_valid = pred_out_valid_q;
    assign pred_taken     = pred_taken_q;
    assign init_done      = init_done_q;
    bp_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (do_upd),
        .head      (head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );
    always_comb begin
        bht_d            = bht_q;
        state_d          = state_q;
        init_idx_d       = init_idx_q;
        init_done_d      = init_done_q;
        pred_out_valid_d = do_pred;
        pred_taken_d     = do_pred ? bht_q[pidx][1] : pred_taken_q;
        if (!run) begin
            bht_d[init_idx_q] = INIT_STATE;
            init_idx_d        = init_idx_q + 1'b1;
            if (init_idx_q == IDX_W'(BHT_DEPTH - 1)) begin
                state_d     = BP_RUN;
                init_done_d = 1'b1;
            end
        end
        if (do_upd) bht_d[uidx] = sat_update(bht_q[uidx], head.taken);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= BP_INIT;
            init_idx_q       <= '0;
            init_done_q      <= 1'b0;
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            init_idx_q       <= init_idx_d;
            init_done_q      <= init_done_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
        end
    end
    always_ff @(posedge clk) begin
        bht_q <= bht_d;
    end
`ifdef BP_PERF_CNT_EN
    logic [15:0] pred_cnt_q, pred_cnt_d, mis_cnt_q, mis_cnt_d;
    always_comb begin
        pred_cnt_d = pred_cnt_q + 16'(do_pred && pred_cnt_q != 16'hFFFF);
        mis_cnt_d  = mis_cnt_q + 16'(push && res_taken != res_pred && mis_cnt_q != 16'hFFFF);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_cnt_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            pred_cnt_q <= pred_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end
    assign perf_pred_cnt    = pred_cnt_q;
    assign perf_mispred_cnt = mis_cnt_q;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: table-driven bench with prediction scoreboard for branch_pred_ctrl
module tb_branch_pred_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic pred_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0, res_pred = 1'b0;
    logic [31:0] pred_pc = '0, res_pc = '0;
    logic pred_ready, pred_out_valid, pred_taken, res_ready, init_done;
`ifdef BP_PERF_CNT_EN
    logic [15:0] perf_pred_cnt, perf_mispred_cnt;
    int npred = 0, nmis = 0;
`endif
    int checks = 0, errors = 0;
    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic        rp;
        logic        rdy;
        logic        taken;
    } vec_t;
    vec_t vq[$];
    logic exp_q[$];
    always #5 clk = ~clk;
    branch_pred_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_ready     (pred_ready),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_pred       (res_pred),
        .res_ready      (res_ready),
        .init_done      (init_done)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_pred_cnt    (perf_pred_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic add(input logic pv, input int ppc, input logic rv, input int rpc,
                       input logic rt, input logic rp, input logic rdy, input logic tk);
        vec_t t;
        t.pv = pv; t.ppc = ppc; t.rv = rv; t.rpc = rpc;
        t.rt = rt; t.rp = rp; t.rdy = rdy; t.taken = tk;
        vq.push_back(t);
    endtask
    task automatic cyc(input vec_t t);
        pred_valid = t.pv; pred_pc = t.ppc;
        res_valid = t.rv; res_pc = t.rpc; res_taken = t.rt; res_pred = t.rp;
        #1;
        chk("pred_ready", pred_ready, t.rdy);
        chk("res_ready", res_ready, t.rdy);
        if (t.pv && t.rdy) exp_q.push_back(t.taken);
        @(posedge clk); #1;
        pred_valid = 1'b0; res_valid = 1'b0;
        if (exp_q.size() > 0) begin
            chk("pred_out_valid", pred_out_valid, 1);
            chk("pred_taken", pred_taken, exp_q.pop_front());
        end else chk("pred_out_valid_idle", pred_out_valid, 0);
    endtask
    task automatic do_reset_init();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_init_done", init_done, 0);
        chk("rst_pred_out_valid", pred_out_valid, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_ready", pred_ready, 0);
        chk("rst_res_ready", res_ready, 0);
        pred_valid = 1'b1; res_valid = 1'b1; res_taken = 1'b1; res_pc = 32'd3;
        for (int i = 0; i < 16; i++) begin
            chk("init_busy", init_done, 0);
            chk("init_pred_ready", pred_ready, 0);
            chk("init_res_ready", res_ready, 0);
            @(posedge clk); #1;
            chk("init_no_pred", pred_out_valid, 0);
        end
        pred_valid = 1'b0; res_valid = 1'b0;
        chk("init_done", init_done, 1);
    endtask
    initial begin
        vec_t t;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_reset_init();
        add(1, 3, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 5, 1, 1, 1, 0);
        add(0, 0, 1, 5, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 5, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 5, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 5, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 2, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 2, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 2, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 2, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 7, 1, 1, 1, 0);
        add(1, 7, 0, 0, 0, 0, 1, 0);
        add(1, 7, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 7, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) add(1, 9, 1, 9, 1, 1, 1, 0);
        add(1, 9, 0, 0, 0, 0, 0, 0);
        add(1, 9, 1, 9, 0, 1, 1, 1);
        add(1, 9, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 9, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 9, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 9, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < vq.size(); i++) begin
`ifdef BP_PERF_CNT_EN
            if (vq[i].pv && vq[i].rdy) npred++;
            if (vq[i].rv && vq[i].rdy && vq[i].rt != vq[i].rp) nmis++;
`endif
            cyc(vq[i]);
        end
`ifdef BP_PERF_CNT_EN
        chk("perf_pred_cnt", 32'(perf_pred_cnt), npred);
        chk("perf_mispred_cnt", 32'(perf_mispred_cnt), nmis);
`endif
        t.pv = 1; t.ppc = 7; t.rv = 1; t.rpc = 12; t.rt = 1; t.rp = 1; t.rdy = 1; t.taken = 1;
        for (int i = 0; i < 3; i++) cyc(t);
        do_reset_init();
`ifdef BP_PERF_CNT_EN
        chk("perf_pred_cnt_rst", 32'(perf_pred_cnt), 0);
        chk("perf_mispred_cnt_rst", 32'(perf_mispred_cnt), 0);
`endif
        t.pv = 0; t.rv = 0; t.taken = 0;
        for (int i = 0; i < 4; i++) cyc(t);
        t.pv = 1; t.ppc = 12;
        cyc(t);
        t.ppc = 7;
        cyc(t);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 16, number of 2-bit counters; IDX_W = log2(BHT_DEPTH).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of pending-update entries.
REQ-003 SHALL have parameter INIT_STATE, default 2'b01, counter value written during init (weakly not-taken).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pred_valid  input  1  fetch requests a prediction.
REQ-008 pred_pc  input  32  PC of branch to predict; index = pred_pc[IDX_W-1:0].
REQ-009 pred_ready  output  1  controller accepts a prediction request this cycle.
REQ-010 pred_out_valid  output  1  pred_taken is valid.
REQ-011 pred_taken  output  1  predicted direction (counter MSB).
REQ-012 res_valid  input  1  execute reports a resolved branch.
REQ-013 res_pc  input  32  PC of resolved branch.
REQ-014 res_taken  input  1  actual outcome.
REQ-015 res_pred  input  1  direction that was predicted for this branch.
REQ-016 res_ready  output  1  pending-update FIFO accepts an entry.
REQ-017 init_done  output  1  table initialisation complete.

Function
REQ-018 SHALL own a BHT_DEPTH x 2-bit register array with one access slot per cycle (read for predict or read-modify-write for update, never both).
REQ-019 FSM states INIT, RUN; INIT writes INIT_STATE to one entry per cycle, index 0 upward; after index BHT_DEPTH-1 -> RUN, init_done=1 next cycle.
REQ-020 In INIT, pred_ready=0, res_ready=0.
REQ-021 Prediction handshake: accepted at cycle N when pred_valid&pred_ready; pred_out_valid=1 and pred_taken=BHT[idx][1] registered at N+1; pred_out_valid=0 otherwise.
REQ-022 Resolve handshake: entry {idx,res_taken,res_pred} enqueued when res_valid&res_ready; res_ready = RUN and count<FIFO_DEPTH.
REQ-023 Arbitration in RUN: if count==FIFO_DEPTH, update wins and pred_ready=0; else if pred_valid, predict wins; else update wins when count>0; pred_ready=1 otherwise.
REQ-024 Update: head entry dequeued, counter saturating +1 if taken, -1 if not; 2'b11 stays on taken, 2'b00 stays on not-taken.
REQ-025 Simultaneous enqueue and dequeue in one cycle SHALL leave count unchanged and preserve order.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Predict to an index with pending updates reads the current array value (no forwarding).

Reset
REQ-028 Reset SHALL force INIT, init index 0, FIFO empty, pred_out_valid=0, pred_taken=0, init_done=0, pred_ready=0, res_ready=0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL discard pending entries and restart INIT from index 0.

Configuration
REQ-030 Macro BP_PERF_CNT_EN: defined -> outputs perf_pred_cnt[15:0] (accepted predictions) and perf_mispred_cnt[15:0] (enqueued entries with res_taken!=res_pred), saturating at 16'hFFFF, cleared by reset; undefined -> ports and logic absent.

Structure
REQ-031 Shared package bp_pkg SHALL hold counter state constants (SNT=00, WNT=01, WT=10, ST=11), FSM state typedef, FIFO entry typedef.
REQ-032 Sub-module bp_update_fifo SHALL implement the pending-update FIFO (push, pop, count, full, empty).

Verification
REQ-033 Reset then 16 cycles -> init_done=1 at cycle 17; predict pc=3 -> pred_taken=0.
REQ-034 Resolve pc=5 taken x2, idle -> BHT[5]=2'b11; predict pc=5 -> pred_taken=1 next cycle; third taken keeps 2'b11.
REQ-035 Hold pred_valid every cycle, enqueue 4 resolves -> FIFO full, pred_ready=0 one cycle, one update drains, res_ready returns 1.
REQ-036 Resolve pc=2 not-taken from 2'b01 -> 2'b00; again -> stays 2'b00.
REQ-037 Enqueue 3 entries then assert reset -> FIFO empty, INIT restarts, no entry applied after INIT.
REQ-038 With BP_PERF_CNT_EN: 3 resolves, one with res_pred!=res_taken -> perf_mispred_cnt=1; 5 accepted predicts -> perf_pred_cnt=5.
